dcache_chi_rdreq: RTL

Downstream neighbour of the dcache MSHR array. It accepts one line-miss request per cycle from the MSHR issue port (`dmshr2chi_*`) and issues it as a line-aligned read on the CHI TXREQ channel, using the MSHR id as TxnID. It collects the two 256-bit RXDAT beats for each outstanding TxnID and returns the assembled 512-bit line to the owning MSHR entry (`chi_arb_resp_*`).

---
 rtl/dcache_chi_rdreq_pkg.sv | 31 +++
 rtl/dcache_chi_rdreq_beat_merge.sv | 58 +++++
 rtl/dcache_chi_rdreq.sv | 115 +++++++++++
 3 files changed

// File: rtl/dcache_chi_rdreq_pkg.sv
// Shared dcache types for the CHI read-request path: line geometry, TXREQ/RXDAT payloads.
// Optional L-credit flow control on TXREQ is selected with DCACHE_CHI_LCRD_EN.
package dcache_chi_rdreq_pkg;

    localparam int PADDR_W       = 40;
    localparam int MSHR_NUM      = 8;
    localparam int MSHR_NUM_LOG  = $clog2(MSHR_NUM);
    localparam int LINE_W        = 512;
    localparam int BEAT_NUM      = 2;
    localparam int HALF_W        = LINE_W / BEAT_NUM;
    localparam int LINE_OFFSET_W = 6;

    typedef logic [PADDR_W-1:0]      paddr_t;
    typedef logic [MSHR_NUM_LOG-1:0] mshrid_t;

    typedef struct packed {
        paddr_t  addr;
        mshrid_t txnid;
    } chi_txreq_t;

    typedef struct packed {
        mshrid_t           txnid;
        logic              dataid;
        logic [HALF_W-1:0] data;
    } chi_rxdat_t;

    function automatic paddr_t line_align(input paddr_t addr);
        return {addr[PADDR_W-1:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
    endfunction

endpackage

// File: rtl/dcache_chi_rdreq_beat_merge.sv
// Per-TxnID half-line buffers: first beat is parked, second beat is merged with it into a
// registered one-cycle refill response.
module chi_beat_merge
    import dcache_chi_rdreq_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alloc_valid,
    input  mshrid_t           alloc_id,
    input  logic              beat_valid,
    input  chi_rxdat_t        beat,
    output logic              complete,
    output logic              resp_valid,
    output mshrid_t           resp_mshrid,
    output logic [LINE_W-1:0] resp_data
);

    logic [HALF_W-1:0]   half_buf [MSHR_NUM];
    logic [MSHR_NUM-1:0] beat_got;
    logic [MSHR_NUM-1:0] beat_got_nxt;
    logic [LINE_W-1:0]   merged;

    assign complete = beat_valid & beat_got[beat.txnid];

    // The parked half needs no dataid of its own: the second beat always carries the other half.
    always_comb begin
        if (beat.dataid) merged = {beat.data, half_buf[beat.txnid]};
        else             merged = {half_buf[beat.txnid], beat.data};
    end

    // A fresh allocation of the same id overrides whatever the beat path did this cycle.
    always_comb begin
        beat_got_nxt = beat_got;
        if (beat_valid)  beat_got_nxt[beat.txnid] = ~beat_got[beat.txnid];
        if (alloc_valid) beat_got_nxt[alloc_id]   = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (beat_valid && !beat_got[beat.txnid]) half_buf[beat.txnid] <= beat.data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_got    <= '0;
            resp_valid  <= 1'b0;
            resp_mshrid <= '0;
            resp_data   <= '0;
        end else begin
            beat_got   <= beat_got_nxt;
            resp_valid <= complete;
            if (complete) begin
                resp_mshrid <= beat.txnid;
                resp_data   <= merged;
            end
        end
    end

endmodule

// File: rtl/dcache_chi_rdreq.sv
// MSHR line-miss to CHI read bridge: single request register onto TXREQ, two-beat RXDAT refill.
// Define DCACHE_CHI_LCRD_EN for L-credit flow control on TXREQ instead of valid/ready.
module dcache_chi_rdreq
    import dcache_chi_rdreq_pkg::*;
#(
    parameter int MAX_CREDIT = 4,
    parameter int BEAT_W     = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              dmshr2chi_valid,
    output logic              dmshr2chi_ready,
    input  paddr_t            dmshr2chi_paddr,
    input  mshrid_t           dmshr2chi_mshrid,
    output logic              txreq_valid,
    input  logic              txreq_ready,
    input  logic              txreq_lcrdv,
    output paddr_t            txreq_addr,
    output mshrid_t           txreq_txnid,
    input  logic              rxdat_valid,
    input  mshrid_t           rxdat_txnid,
    input  logic              rxdat_dataid,
    input  logic [BEAT_W-1:0] rxdat_data,
    output logic              chi_arb_resp_valid,
    output mshrid_t           chi_arb_resp_mshrid,
    output logic [LINE_W-1:0] chi_arb_resp_data
);

    logic                req_vld;
    chi_txreq_t          req;
    logic                txreq_fire;
    logic                accept;
    logic [MSHR_NUM-1:0] outstanding;
    logic [MSHR_NUM-1:0] outstanding_nxt;
    logic                beat_valid;
    logic                complete;
    chi_rxdat_t          rxdat;

`ifdef DCACHE_CHI_LCRD_EN
    localparam int CREDIT_W = $clog2(MAX_CREDIT + 1);

    logic [CREDIT_W-1:0] credit;
    logic                unused_txreq_ready;

    assign unused_txreq_ready = txreq_ready;
    assign txreq_valid        = req_vld & (credit != '0);
    assign txreq_fire         = txreq_valid;

    // A grant and a fire in the same cycle cancel out, even at saturation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            credit <= '0;
        end else if (txreq_lcrdv && !txreq_fire) begin
            if (credit != CREDIT_W'(MAX_CREDIT)) credit <= credit + 1'b1;
        end else if (txreq_fire && !txreq_lcrdv) begin
            credit <= credit - 1'b1;
        end
    end
`else
    localparam int unused_max_credit = MAX_CREDIT;

    logic unused_txreq_lcrdv;

    assign unused_txreq_lcrdv = txreq_lcrdv;
    assign txreq_valid        = req_vld;
    assign txreq_fire         = txreq_valid & txreq_ready;
`endif

    assign dmshr2chi_ready = ~req_vld | txreq_fire;
    assign accept          = dmshr2chi_valid & dmshr2chi_ready;
    assign txreq_addr      = req.addr;
    assign txreq_txnid     = req.txnid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_vld <= 1'b0;
            req     <= '0;
        end else if (accept) begin
            req_vld   <= 1'b1;
            req.addr  <= line_align(dmshr2chi_paddr);
            req.txnid <= dmshr2chi_mshrid;
        end else if (txreq_fire) begin
            req_vld <= 1'b0;
        end
    end

    // Beats for ids that are not in flight (stale or post-reset) never reach the merge buffers.
    assign rxdat      = '{txnid: rxdat_txnid, dataid: rxdat_dataid, data: rxdat_data};
    assign beat_valid = rxdat_valid & outstanding[rxdat_txnid];

    always_comb begin
        outstanding_nxt = outstanding;
        if (complete) outstanding_nxt[rxdat_txnid]      = 1'b0;
        if (accept)   outstanding_nxt[dmshr2chi_mshrid] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) outstanding <= '0;
        else          outstanding <= outstanding_nxt;
    end

    chi_beat_merge u_beat_merge (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc_valid (accept),
        .alloc_id    (dmshr2chi_mshrid),
        .beat_valid  (beat_valid),
        .beat        (rxdat),
        .complete    (complete),
        .resp_valid  (chi_arb_resp_valid),
        .resp_mshrid (chi_arb_resp_mshrid),
        .resp_data   (chi_arb_resp_data)
    );

endmodule
